// File: rtl/freq_uart_formatter.sv
// freq_uart_formatter: turns each binary Hz measurement into the ASCII line
// "<decimal>[ Hz]\r\n" and streams it byte by byte over a valid/ready port.
// The binary-to-decimal step is a serial double-dabble, one input bit per clock.
module freq_uart_formatter #(
  parameter int WIDTH     = 32,
  parameter int DIGITS    = 10,
  parameter int SUFFIX_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freq_valid,
  input  logic [WIDTH-1:0] freq_value,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             dropped
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  // Number of trailer bytes: " Hz\r\n" or just "\r\n"
  localparam logic [2:0] SUF_LEN = (SUFFIX_EN != 0) ? 3'd5 : 3'd2;

  typedef enum logic [2:0] {IDLE, CONV, SKIP, SEND_DIG, SEND_SUF} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [DIG_W-1:0]   dig_idx_reg;
  logic [DIG_W-1:0]   msd_idx;
  logic [3:0]         cur_digit;
  logic [2:0]         suf_idx_reg;
  logic [7:0]         suf_byte;
  logic [7:0]         tx_data_reg;
  logic               tx_valid_reg;
  logic               busy_reg;
  logic               dropped_reg;
  logic               accepted;
  logic               load_byte;
  logic               suf_last;

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign dropped  = dropped_reg;

  // A new byte may be loaded when the output slot is empty or is being drained
  assign accepted  = tx_valid_reg && tx_ready;
  assign load_byte = !tx_valid_reg || tx_ready;
  assign suf_last  = (suf_idx_reg == SUF_LEN);

  // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Priority-encode the most significant non-zero digit (0 if value is zero)
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0) msd_idx = DIG_W'(i);
    end
  end

  // Select the digit currently being transmitted
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx_reg == DIG_W'(i)) cur_digit = bcd_reg[4*i +: 4];
    end
  end

  // Trailer byte lookup
  always_comb begin
    suf_byte = 8'h0A;
    if (SUFFIX_EN != 0) begin
      case (suf_idx_reg)
        3'd0:    suf_byte = 8'h20;
        3'd1:    suf_byte = 8'h48;
        3'd2:    suf_byte = 8'h7A;
        3'd3:    suf_byte = 8'h0D;
        default: suf_byte = 8'h0A;
      endcase
    end else begin
      suf_byte = (suf_idx_reg == 3'd0) ? 8'h0D : 8'h0A;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (freq_valid) state_next = CONV;
      CONV:     if (bit_cnt_reg == LAST_BIT) state_next = SKIP;
      SKIP:     state_next = SEND_DIG;
      SEND_DIG: if (load_byte && dig_idx_reg == '0) state_next = SEND_SUF;
      SEND_SUF: if (suf_last && accepted) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: capture, conversion, byte loading and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      bcd_reg      <= '0;
      bit_cnt_reg  <= '0;
      dig_idx_reg  <= '0;
      suf_idx_reg  <= '0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      dropped_reg  <= 1'b0;
    end else begin
      dropped_reg <= freq_valid && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (freq_valid) begin
            shift_reg   <= freq_value;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            suf_idx_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        CONV: begin
          bcd_reg     <= {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
          shift_reg   <= shift_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        SKIP: dig_idx_reg <= msd_idx;
        SEND_DIG: begin
          if (load_byte) begin
            tx_data_reg  <= 8'h30 + {4'h0, cur_digit};
            tx_valid_reg <= 1'b1;
            if (dig_idx_reg != '0) dig_idx_reg <= dig_idx_reg - 1'b1;
            else                   suf_idx_reg <= '0;
          end
        end
        SEND_SUF: begin
          if (!suf_last && load_byte) begin
            tx_data_reg  <= suf_byte;
            tx_valid_reg <= 1'b1;
            suf_idx_reg  <= suf_idx_reg + 3'd1;
          end else if (suf_last && accepted) begin
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_uart_formatter.sv
// Testbench for freq_uart_formatter: directed lines, scoreboard queue of
// expected bytes, negedge monitor popping on every accepted handshake.
module tb_freq_uart_formatter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         freq_valid = 1'b0;
  logic [W-1:0] freq_value = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         busy;
  logic         dropped;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;
  int ready_mode = 0;

  freq_uart_formatter #(.WIDTH(W), .DIGITS(10), .SUFFIX_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .freq_valid(freq_valid), .freq_value(freq_value),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ready driver: always ready, or ready only every 7th cycle
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 7) == 0);
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (dropped) drop_cnt++;
        if (prev_valid && !prev_ready) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%02h required=none", tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            $display("tx byte actual=%02h expected=%02h", tx_data, exp_b);
            check("byte", tx_data, exp_b);
          end
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Returns #1 after the capture edge
  task automatic strobe(input logic [W-1:0] v);
    @(posedge clk); #1;
    freq_value = v;
    freq_valid = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid_timeout", (n < 200), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_timeout"}, (n < 2000), 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int n;
    int drops0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: 1000, latency and gap-free streaming
    push_line("1000");
    strobe(32'd1000);
    check("t1_busy_high", busy, 1);
    wait_valid(n);
    check("t1_latency", n, 34);
    for (int k = 0; k < 9; k++) begin
      check("t1_no_gap", tx_valid, 1);
      @(posedge clk); #1;
    end
    check("t1_valid_low_after", tx_valid, 0);
    check("t1_busy_low_after", busy, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // 2: zero prints as a single "0"
    push_line("0");
    strobe(32'd0);
    wait_done("t2");

    // 3: full-scale value, all ten digits
    push_line("4294967295");
    strobe(32'hFFFF_FFFF);
    wait_done("t3");

    // 4: back-pressure, ready every 7th cycle
    ready_mode = 1;
    push_line("50000000");
    strobe(32'd50000000);
    wait_done("t4");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // 5: strobe during the 3rd byte is dropped; line stays intact
    drops0 = drop_cnt;
    push_line("1000");
    strobe(32'd1000);
    wait_valid(n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    freq_value = 32'd7;
    freq_valid = 1'b1;
    @(posedge clk); #1;
    freq_valid = 1'b0;
    check("t5_dropped_pulse", dropped, 1);
    @(posedge clk); #1;
    check("t5_dropped_one_cycle", dropped, 0);
    wait_done("t5a");
    check("t5_drop_count", drop_cnt - drops0, 1);
    push_line("7");
    strobe(32'd7);
    wait_done("t5b");

    // 6: reset during the 2nd digit, then a clean line
    push_line("4294967295");
    strobe(32'hFFFF_FFFF);
    wait_valid(n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", tx_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_data", tx_data, 8'h00);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_resume", tx_valid, 0);
    push_line("12");
    strobe(32'd12);
    wait_done("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
